// File: rtl/reset_pulse_generator.sv
// reset_pulse_generator
//
// Gathers reset requests from several sources and stretches any accepted
// request into a reset pulse with a fixed width. A hold-off window with
// reset_out low follows every pulse. Sticky cause and power-on flags are
// kept for software readback.
//
// Ports:
//   clk          block clock
//   reset        synchronous, active-high reset (starts a power-on pulse)
//   req          per-source reset request, sampled every cycle
//   req_mask     per-source mask, 1 = source ignored
//   cause_clear  one-cycle pulse that clears cause and por
//   reset_out    registered reset pulse for the downstream synchronizers
//   busy         high while a pulse or its hold-off window is in progress
//   done         one-cycle pulse in the first hold-off cycle
//   cause        sticky OR of all accepted request sources
//   por          sticky power-on flag
module reset_pulse_generator #(
  parameter int NUM_SRC        = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] req_mask,
  input  logic               cause_clear,
  output logic               reset_out,
  output logic               busy,
  output logic               done,
  output logic [NUM_SRC-1:0] cause,
  output logic               por
);

  localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              pend;
  logic              pend_next;
  logic [NUM_SRC-1:0] eff;
  logic              any_req;

  assign eff     = req & ~req_mask;
  assign any_req = |eff;

  // State register plus the sticky flags and the registered pulse output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      pend      <= 1'b0;
      reset_out <= 1'b1;
      cause     <= '0;
      por       <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pend      <= pend_next;
      // Registered copy of the next state keeps req off any combinational
      // path to reset_out while still rising on the accepting edge.
      reset_out <= (state_next == ASSERT);
      // New eff bits are ORed in after the clear so a same-cycle capture wins.
      cause     <= (cause_clear ? '0 : cause) | eff;
      por       <= cause_clear ? 1'b0 : por;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    pend_next  = pend;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (any_req) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt == PULSE_LAST) begin
          state_next = HOLDOFF;
          cnt_next   = '0;
        end
      end
      HOLDOFF: begin
        if (any_req) begin
          pend_next = 1'b1;
        end
        if (cnt == HOLD_LAST) begin
          cnt_next   = '0;
          pend_next  = 1'b0;
          state_next = (pend || any_req) ? ASSERT : IDLE;
        end
      end
      default: begin
        state_next = ASSERT;
        cnt_next   = '0;
        pend_next  = 1'b0;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == HOLDOFF) && (cnt == '0);
  end

endmodule

// File: tb/tb_reset_pulse_generator.sv
// tb_reset_pulse_generator
//
// Self-checking bench for reset_pulse_generator. Stimulus sequences push the
// expected reset_out pulse widths, low gaps and busy run lengths onto queues;
// a negedge monitor measures the DUT outputs and pops/compares them.
module tb_reset_pulse_generator;

  localparam int NSRC = 4;
  localparam int P    = 16;
  localparam int H    = 8;

  typedef struct {
    int high;
    int gap;   // required low cycles before this pulse, -1 = not checked
  } pulse_exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] req = '0;
  logic [NSRC-1:0] req_mask = '0;
  logic            cause_clear = 1'b0;
  logic            reset_out;
  logic            busy;
  logic            done;
  logic [NSRC-1:0] cause;
  logic            por;

  reset_pulse_generator #(
    .NUM_SRC(NSRC),
    .PULSE_CYCLES(P),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_mask(req_mask),
    .cause_clear(cause_clear),
    .reset_out(reset_out),
    .busy(busy),
    .done(done),
    .cause(cause),
    .por(por)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int done_cnt = 0;

  pulse_exp_t pulse_q[$];
  int         busy_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_pulse(input int high, input int gap);
    pulse_exp_t e;
    e.high = high;
    e.gap  = gap;
    pulse_q.push_back(e);
    n_pulses++;
  endtask

  task automatic expect_busy(input int len);
    busy_q.push_back(len);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    check("idle_reached", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic pulse_req(input logic [NSRC-1:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  // Output monitor: measures run lengths away from the active edge.
  logic prev_ro = 1'b0;
  logic prev_busy = 1'b0;
  int   hi_len = 0;
  int   lo_len = 0;
  int   busy_len = 0;

  always @(negedge clk) begin
    pulse_exp_t e;
    int         b;
    if (done === 1'b1) done_cnt++;
    if (reset_out === 1'b1) begin
      if (!prev_ro) begin
        if (pulse_q.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
        else if (pulse_q[0].gap >= 0) check("pulse_gap", lo_len, pulse_q[0].gap);
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_ro) begin
        check("done_after_pulse", {31'd0, done}, 32'd1);
        if (pulse_q.size() != 0) begin
          e = pulse_q.pop_front();
          check("pulse_len", hi_len, e.high);
        end
        lo_len = 0;
      end
      lo_len++;
    end
    if (busy === 1'b1) begin
      if (!prev_busy) begin
        if (busy_q.size() == 0) check("busy_unexpected", 32'd1, 32'd0);
        busy_len = 0;
      end
      busy_len++;
    end else if (prev_busy) begin
      if (busy_q.size() != 0) begin
        b = busy_q.pop_front();
        check("busy_len", busy_len, b);
      end
    end
    prev_ro   = (reset_out === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on: reset sampled on 5 edges; the cycle after the last reset edge
    // is the first of the 16 ASSERT cycles, so 4 + 16 high cycles are seen.
    expect_pulse(5 + P - 1, -1);
    expect_busy(5 + P - 1 + H);
    tick();
    check("rst_reset_out", {31'd0, reset_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_por", {31'd0, por}, 32'd1);
    check("rst_cause", {28'd0, cause}, 32'd0);
    repeat (4) tick();
    reset = 1'b0;
    wait_idle();
    check("po_por", {31'd0, por}, 32'd1);
    check("po_cause", {28'd0, cause}, 32'd0);

    // Single one-cycle request.
    expect_pulse(P, -1);
    expect_busy(P + H);
    pulse_req(4'b0100);
    wait_idle();
    check("single_cause", {28'd0, cause}, 32'h4);
    check("single_por", {31'd0, por}, 32'd1);

    // Clear racing with an accepted request: the new bit survives.
    expect_pulse(P, -1);
    expect_busy(P + H);
    req = 4'b0010;
    cause_clear = 1'b1;
    tick();
    req = '0;
    cause_clear = 1'b0;
    check("clr_cause", {28'd0, cause}, 32'h2);
    check("clr_por", {31'd0, por}, 32'd0);
    wait_idle();

    cause_clear = 1'b1;
    tick();
    cause_clear = 1'b0;
    check("clear_cause", {28'd0, cause}, 32'd0);

    // Merge in ASSERT, then a pending request from HOLDOFF cycle 3.
    expect_pulse(P, -1);
    expect_pulse(P, H);
    expect_busy(2 * (P + H));
    pulse_req(4'b0001);           // accepted at edge E
    repeat (5) tick();            // now in ASSERT cnt 5
    pulse_req(4'b0010);           // merged
    check("merge_cause", {28'd0, cause}, 32'h3);
    repeat (13) tick();           // now in HOLDOFF cnt 3
    pulse_req(4'b0100);           // becomes pend
    wait_idle();
    check("pend_cause", {28'd0, cause}, 32'h7);

    cause_clear = 1'b1;
    tick();
    cause_clear = 1'b0;

    // Masked source held for 50 cycles, then unmasked while still held.
    req_mask = 4'b1000;
    req = 4'b1000;
    repeat (50) tick();
    check("mask_reset_out", {31'd0, reset_out}, 32'd0);
    check("mask_busy", {31'd0, busy}, 32'd0);
    check("mask_cause", {28'd0, cause}, 32'd0);
    expect_pulse(P, -1);
    expect_pulse(P, H);
    expect_pulse(P, H);
    expect_busy(3 * (P + H));
    req_mask = '0;
    tick();                       // accepted at edge U
    repeat (55) tick();           // third pulse, ASSERT cnt 7
    req = '0;
    wait_idle();
    check("unmask_cause", {28'd0, cause}, 32'h8);

    // Reset asserted in ASSERT cycle 7 for two edges: the pulse stretches
    // over 8 ASSERT cycles, 2 reset cycles and the 15 remaining restart cycles.
    expect_pulse(8 + 2 + P - 1, -1);
    expect_busy(8 + 2 + P - 1 + H);
    pulse_req(4'b0001);
    repeat (7) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wait_idle();
    check("rmid_cause", {28'd0, cause}, 32'd0);
    check("rmid_por", {31'd0, por}, 32'd1);

    // Reset in HOLDOFF with a pending request: pend is dropped, so only the
    // restarted power-on pulse follows (4 low cycles before it).
    expect_pulse(P, -1);
    expect_pulse(P, 4);
    expect_busy(20 + P + H);
    pulse_req(4'b0001);           // edge E
    repeat (18) tick();           // HOLDOFF cnt 2
    pulse_req(4'b0100);           // pend set at edge E+19
    reset = 1'b1;
    tick();                       // edge E+20
    reset = 1'b0;
    wait_idle();
    repeat (30) tick();
    check("rhold_reset_out", {31'd0, reset_out}, 32'd0);
    check("rhold_cause", {28'd0, cause}, 32'd0);

    check("done_count", done_cnt, n_pulses);
    check("pulse_q_empty", pulse_q.size(), 32'd0);
    check("busy_q_empty", busy_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_pulse_generator.md
# reset_pulse_generator

Single-clock reset-request source that produces the raw reset pulse consumed by the per-domain reset synchronizers. It collects reset requests from several sources (software, watchdog, debug), masks them, and stretches any accepted request to a fixed minimum pulse width. A hold-off window follows each pulse so downstream domains can come out of reset cleanly. Sticky cause and power-on flags are kept for software readback.

## Interface
- `NUM_SRC`, 4: number of request sources; ≥1.
- `PULSE_CYCLES`, 16: `reset_out` high time per pulse, in cycles; ≥2.
- `HOLDOFF_CYCLES`, 8: minimum low time after each pulse; ≥1.
- Counter width: `$clog2(max(PULSE_CYCLES,HOLDOFF_CYCLES))+1`.

- `clk`  in  1  block clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_SRC  per-source reset request, sampled every cycle; one cycle is enough.
- `req_mask`  in  NUM_SRC  1 = source ignored.
- `cause_clear`  in  1  one-cycle pulse that clears `cause` and `por`.
- `reset_out`  out  1  registered reset pulse; drives the synchronizer's async-reset input.
- `busy`  out  1  high in ASSERT or HOLDOFF.
- `done`  out  1  one-cycle pulse in the first HOLDOFF cycle.
- `cause`  out  NUM_SRC  sticky OR of accepted sources.
- `por`  out  1  sticky power-on flag.

## Operation
- `eff = req & ~req_mask`. A request is any bit of `eff` set.
- **FSM states:** IDLE, ASSERT, HOLDOFF, with count register `cnt`. `pend` is a one-bit register.
- **`reset` high:** state = ASSERT, `cnt = 0`, `pend = 0`, `por = 1`, `cause = 0`.
  - Outputs during reset: `reset_out = 1`, `busy = 1`, `done = 0`.
  - After reset deasserts, the FSM completes a full ASSERT pulse (power-on pulse).
- **IDLE:**
  - If a request is present: go to ASSERT, `cnt = 0`, `cause |= eff`.
  - Otherwise: stay in IDLE.
- **ASSERT:**
  - Each cycle: `cnt++` and `cause |= eff`.
  - Requests arriving in ASSERT merge into the current pulse; no extra pulse is generated.
  - When `cnt == PULSE_CYCLES-1`: go to HOLDOFF, `cnt = 0`.
- **HOLDOFF:**
  - Each cycle: `cnt++`.
  - Any request sets `pend = 1` and `cause |= eff`.
  - When `cnt == HOLDOFF_CYCLES-1`:
    - if `pend`, or a request is present this cycle: go to ASSERT, clear `pend`;
    - otherwise: go to IDLE.
- **Level behaviour:** a request held high continuously produces back-to-back pulses separated by exactly HOLDOFF_CYCLES.
- **Outputs:**
  - `reset_out` is registered and equals (next state == ASSERT); no combinational path from `req`.
  - `busy` = state != IDLE.
- **`cause_clear`:**
  - Zeroes `cause` and `por`.
  - If `eff` bits are captured in the same cycle, those new bits win; they are set after the clear.
- **Masking:**
  - A masked source never starts a pulse, never sets `pend`, never sets `cause`.
  - Changing the mask mid-pulse does not shorten the pulse.

## Timing
- Request sampled at rising edge E while in IDLE:
  - `reset_out` is high for cycles E+1 through E+PULSE_CYCLES, exactly PULSE_CYCLES cycles.
  - `done` is high in cycle E+PULSE_CYCLES+1.
  - `busy` falls after HOLDOFF_CYCLES low cycles.
  - Earliest next accepted request: the first IDLE cycle, E+PULSE_CYCLES+HOLDOFF_CYCLES+1. Its pulse rises one cycle later.
- Reset deasserted at edge R: `reset_out` stays high through cycle R+PULSE_CYCLES-1, then falls.
- Reset asserted mid-pulse or mid-holdoff:
  - `reset_out = 1` from the next edge;
  - `pend` is dropped;
  - a full pulse restarts after release.
- Minimum `reset_out` low time between pulses: HOLDOFF_CYCLES, always.

## Test plan
- **Power-on:** `reset` high for 5 cycles, then low.
  - `reset_out` high during reset plus 16 cycles, then low.
  - `por = 1`, `cause = 0`, `done` pulses once.
- **Single request:** PULSE=16, HOLDOFF=8; in IDLE, one-cycle `req = 4'b0100`.
  - `reset_out` high for exactly 16 cycles starting the next cycle.
  - `cause = 4'b0100`; `busy` high for 24 cycles.
- **Merge and pend:**
  - `req[0]` during IDLE, then `req[1]` in ASSERT cycle 5: one pulse only, `cause = 4'b0011`.
  - `req[2]` in HOLDOFF cycle 3: a second pulse starts exactly 8 low cycles after the first.
- **Masking:** `req_mask = 4'b1000` and `req[3]` held for 50 cycles.
  - `reset_out` stays 0, `busy` 0, `cause` 0.
  - Unmasking with `req[3]` still held: pulse train of 16 high / 8 low.
- **Clear race:** `cause_clear` in the same cycle as `req[1]` is accepted.
  - `cause = 4'b0010`, `por = 0`.
- **Reset mid-pulse:** assert `reset` at ASSERT cycle 7.
  - `reset_out` stays high; after release, a full 16-cycle pulse.
  - `cause = 0`, `por = 1`, no pending pulse follows.
